// File: rtl/api_rx_parser_pkg.sv
// Shared definitions for the API RX response parser: block geometry,
// framing constants, parser state encoding and small helper functions.
package api_rx_parser_pkg;

  // Response block geometry (words, indices within a block)
  localparam int RX_BLOCK_LEN = 11;
  localparam int NONCE_IDX    = 2;
  localparam int MARK_IDX     = 9;
  localparam int LAST_IDX     = RX_BLOCK_LEN - 1;

  // Framing constants
  localparam logic [31:0] MARK_VAL = 32'hbeafbeaf;
  localparam logic [7:0]  TAG_VAL  = 8'h12;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_READ   = 3'd1,
    ST_CHECK  = 3'd2,
    ST_EMIT   = 3'd3,
    ST_RESYNC = 3'd4
  } rx_state_t;

  // A word closes a block when it carries the tag and a zero reserved nibble.
  function automatic logic tag_ok(input logic [31:0] w);
    return (w[15:8] == TAG_VAL) && (w[7:4] == 4'h0);
  endfunction

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hffff) ? v : (v + 16'd1);
  endfunction

endpackage

// File: rtl/api_rx_dupfilt.sv
// Per-miner last-nonce store for the RX parser duplicate filter.
// Holds the most recently emitted nonce and a valid bit for each of the
// 16 miner ids; flags a candidate nonce that repeats the stored one.
module api_rx_dupfilt
  import api_rx_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_rst,
  input  logic [3:0]  i_miner_id,
  input  logic [31:0] i_nonce,
  output logic        o_dup,
  input  logic        i_wr_en,
  input  logic [3:0]  i_wr_miner_id,
  input  logic [31:0] i_wr_nonce
);

  logic [15:0] r_vld;
  logic [31:0] r_nonce [16];

  // Record each emitted nonce against its miner; clears forget all history.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        r_nonce[i] <= 32'h0000_0000;
      end
    end else if (reg_rst) begin
      r_vld <= 16'h0000;
      for (int i = 0; i < 16; i++) begin
        r_nonce[i] <= 32'h0000_0000;
      end
    end else if (i_wr_en) begin
      r_vld[i_wr_miner_id]   <= 1'b1;
      r_nonce[i_wr_miner_id] <= i_wr_nonce;
    end else begin
      r_vld <= r_vld;
    end
  end

  // Candidate is a duplicate only when that miner already has a stored nonce.
  always_comb begin
    o_dup = r_vld[i_miner_id] && (r_nonce[i_miner_id] == i_nonce);
  end

endmodule

// File: rtl/api_rx_parser.sv
// API RX response parser: drains fixed-length chip response blocks from the
// FWFT RX FIFO, checks framing, and emits one record per nonce on a
// valid/ready stream. Keeps saturating nonce and framing-error counters and
// skips to the next block boundary after a corrupt block.
// Optional build macro: API_RX_DUP_FILTER_EN (drop repeated nonces per miner).
module api_rx_parser
  import api_rx_parser_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_rst,
  input  logic        rx_fifo_empty,
  input  logic [31:0] rx_fifo_dout,
  input  logic [9:0]  rx_fifo_data_count,
  output logic        rx_fifo_rd_en,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_nonce,
  output logic [31:0] out_job,
  output logic [15:0] out_chip,
  output logic [3:0]  out_miner_id,
  output logic [15:0] nonce_cnt,
  output logic [15:0] err_cnt,
  output logic        busy
);

  localparam logic [3:0] IDX_FIRST = 4'd0;
  localparam logic [3:0] IDX_NONCE = 4'(NONCE_IDX);
  localparam logic [3:0] IDX_MARK  = 4'(MARK_IDX);
  localparam logic [3:0] IDX_LAST  = 4'(LAST_IDX);
  localparam logic [9:0] BLOCK_WORDS = 10'(RX_BLOCK_LEN);

  rx_state_t   r_state;
  rx_state_t   w_state_nxt;
  logic [3:0]  r_idx;
  logic [31:0] r_word_job;
  logic [31:0] r_word_nonce;
  logic [31:0] r_word_mark;
  logic [31:0] r_word_last;

  logic        r_out_valid;
  logic [31:0] r_out_nonce;
  logic [31:0] r_out_job;
  logic [15:0] r_out_chip;
  logic [3:0]  r_out_miner;
  logic [15:0] r_nonce_cnt;
  logic [15:0] r_err_cnt;

  logic        w_rd_en;
  logic        w_load_out;
  logic        w_handshake;
  logic        w_err_inc;
  logic        w_tag_ok;
  logic        w_mark_ok;
  logic        w_dup;
  logic        w_emit;

  assign w_tag_ok  = tag_ok(r_word_last);
  assign w_mark_ok = (r_word_mark == MARK_VAL);
  assign w_emit    = w_tag_ok && w_mark_ok && !w_dup;

`ifdef API_RX_DUP_FILTER_EN
  api_rx_dupfilt u_dupfilt (
    .clk           (clk),
    .rst           (rst),
    .reg_rst       (reg_rst),
    .i_miner_id    (r_word_last[3:0]),
    .i_nonce       (r_word_nonce),
    .o_dup         (w_dup),
    .i_wr_en       (w_handshake),
    .i_wr_miner_id (r_out_miner),
    .i_wr_nonce    (r_out_nonce)
  );
`else
  assign w_dup = 1'b0;
`endif

  // FSM state register; soft clear returns to IDLE from any state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else if (reg_rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state logic.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (rx_fifo_data_count >= BLOCK_WORDS) begin
          w_state_nxt = ST_READ;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_READ: begin
        if (w_rd_en && (r_idx == IDX_LAST)) begin
          w_state_nxt = ST_CHECK;
        end else begin
          w_state_nxt = ST_READ;
        end
      end
      ST_CHECK: begin
        if (!w_tag_ok) begin
          w_state_nxt = ST_RESYNC;
        end else if (w_emit) begin
          w_state_nxt = ST_EMIT;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (out_ready) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_EMIT;
        end
      end
      ST_RESYNC: begin
        if (w_rd_en && tag_ok(rx_fifo_dout)) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_RESYNC;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // FSM outputs: FIFO pops (held off during soft clear) and datapath strobes.
  always_comb begin
    w_rd_en     = 1'b0;
    w_load_out  = 1'b0;
    w_handshake = 1'b0;
    w_err_inc   = 1'b0;
    case (r_state)
      ST_READ, ST_RESYNC: begin
        w_rd_en = !rx_fifo_empty && !reg_rst;
      end
      ST_CHECK: begin
        w_load_out = w_emit;
        w_err_inc  = !w_tag_ok;
      end
      ST_EMIT: begin
        w_handshake = out_ready;
      end
      default: begin
        w_rd_en = 1'b0;
      end
    endcase
  end

  // Capture the words of interest as the block streams out of the FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx        <= 4'd0;
      r_word_job   <= 32'h0000_0000;
      r_word_nonce <= 32'h0000_0000;
      r_word_mark  <= 32'h0000_0000;
      r_word_last  <= 32'h0000_0000;
    end else if (reg_rst) begin
      r_idx        <= 4'd0;
      r_word_job   <= 32'h0000_0000;
      r_word_nonce <= 32'h0000_0000;
      r_word_mark  <= 32'h0000_0000;
      r_word_last  <= 32'h0000_0000;
    end else if ((r_state == ST_READ) && w_rd_en) begin
      case (r_idx)
        IDX_FIRST: r_word_job   <= rx_fifo_dout;
        IDX_NONCE: r_word_nonce <= rx_fifo_dout;
        IDX_MARK:  r_word_mark  <= rx_fifo_dout;
        IDX_LAST:  r_word_last  <= rx_fifo_dout;
        default:   r_word_job   <= r_word_job;
      endcase
      r_idx <= (r_idx == IDX_LAST) ? 4'd0 : (r_idx + 4'd1);
    end else begin
      r_idx <= r_idx;
    end
  end

  // Output record: loaded on a good block, held until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_nonce <= 32'h0000_0000;
      r_out_job   <= 32'h0000_0000;
      r_out_chip  <= 16'h0000;
      r_out_miner <= 4'h0;
    end else if (reg_rst) begin
      r_out_valid <= 1'b0;
      r_out_nonce <= 32'h0000_0000;
      r_out_job   <= 32'h0000_0000;
      r_out_chip  <= 16'h0000;
      r_out_miner <= 4'h0;
    end else if (w_load_out) begin
      r_out_valid <= 1'b1;
      r_out_nonce <= r_word_nonce;
      r_out_job   <= r_word_job;
      r_out_chip  <= r_word_last[31:16];
      r_out_miner <= r_word_last[3:0];
    end else if (w_handshake) begin
      r_out_valid <= 1'b0;
    end else begin
      r_out_valid <= r_out_valid;
    end
  end

  // Saturating statistics: accepted records and framing errors.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_nonce_cnt <= 16'h0000;
      r_err_cnt   <= 16'h0000;
    end else if (reg_rst) begin
      r_nonce_cnt <= 16'h0000;
      r_err_cnt   <= 16'h0000;
    end else begin
      r_nonce_cnt <= w_handshake ? sat_inc16(r_nonce_cnt) : r_nonce_cnt;
      r_err_cnt   <= w_err_inc   ? sat_inc16(r_err_cnt)   : r_err_cnt;
    end
  end

  assign rx_fifo_rd_en = w_rd_en;
  assign out_valid     = r_out_valid;
  assign out_nonce     = r_out_nonce;
  assign out_job       = r_out_job;
  assign out_chip      = r_out_chip;
  assign out_miner_id  = r_out_miner;
  assign nonce_cnt     = r_nonce_cnt;
  assign err_cnt       = r_err_cnt;
  assign busy          = (r_state != ST_IDLE);

endmodule
